gen_framestart_multi: RTL and testbench



---
 rtl/gen_framestart_multi.sv | 137 +++++++++++++
 tb/tb_gen_framestart_multi.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_framestart_multi.sv
// Multi-channel frame-start generator: one master period counter drives a master pulse and
// NUM_CH delayed trigger pulses of programmable width, with free-run, single-shot and graceful stop.
module gen_framestart_multi #(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 32,
   parameter int PW_W   = 16,
   parameter int FCNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic                    i_stop,
   input  logic                    i_mode,
   input  logic [CNT_W-1:0]        i_period,
   input  logic [PW_W-1:0]         i_pulse_w,
   input  logic [NUM_CH-1:0]       i_ch_en,
   input  logic [NUM_CH*CNT_W-1:0] i_ch_delay,
   output logic                    o_master_fs,
   output logic [NUM_CH-1:0]       o_fs,
   output logic                    o_busy,
   output logic [FCNT_W-1:0]       o_frame_cnt,
   output logic                    o_cfg_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

   state_e            state_q;
   logic              start_d1_q;
   logic              mode_q;
   logic [CNT_W-1:0]  period_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [PW_W-1:0]   pw_q;
   logic [NUM_CH-1:0] ch_en_q;
   logic [CNT_W-1:0]  delay_q [NUM_CH];
   logic [PW_W-1:0]   m_rem_q;
   logic [PW_W-1:0]   ch_rem_q [NUM_CH];
   logic              master_q;
   logic [NUM_CH-1:0] fs_q;
   logic [FCNT_W-1:0] frame_cnt_q;
   logic              cfg_err_q;

   logic              start_re;
   logic [PW_W-1:0]   eff_pw;
   logic              cfg_bad;
   logic              cnt_last;
   logic              m_trig;
   logic [NUM_CH-1:0] ch_trig;
   logic [NUM_CH-1:0] delay_bad;

   assign start_re = i_start & ~start_d1_q;
   assign eff_pw   = (i_pulse_w == '0) ? PW_W'(1) : i_pulse_w;
   assign cfg_bad  = (i_period < CNT_W'(2)) || (CNT_W'(eff_pw) >= i_period);
   assign cnt_last = (cnt_q == period_q - CNT_W'(1));
   assign m_trig   = (state_q == ST_RUN) && (cnt_q == '0);

   // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
   always_comb begin
      delay_bad = '0;
      ch_trig   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         delay_bad[k] = (i_ch_delay[k*CNT_W +: CNT_W] >= i_period);
         // A delay at or beyond the period never matches because cnt_q stays below period_q.
         ch_trig[k]   = (state_q == ST_RUN) && ch_en_q[k] && (cnt_q == delay_q[k]);
      end
   end

   // NOTE: non-blocking assignments throughout, so every term below reads pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         start_d1_q  <= 1'b0;
         mode_q      <= 1'b0;
         period_q    <= '0;
         cnt_q       <= '0;
         pw_q        <= '0;
         ch_en_q     <= '0;
         m_rem_q     <= '0;
         master_q    <= 1'b0;
         fs_q        <= '0;
         frame_cnt_q <= '0;
         cfg_err_q   <= 1'b0;
         // NOTE: the small delay/width arrays are reset as well; they feed the trigger compares.
         for (int k = 0; k < NUM_CH; k++) begin
            delay_q[k]  <= '0;
            ch_rem_q[k] <= '0;
         end
      end else begin
         start_d1_q <= i_start;

         master_q <= m_trig || (m_rem_q > PW_W'(1));
         m_rem_q  <= m_trig ? pw_q : ((m_rem_q != '0) ? m_rem_q - PW_W'(1) : '0);
         for (int k = 0; k < NUM_CH; k++) begin
            fs_q[k]     <= ch_trig[k] || (ch_rem_q[k] > PW_W'(1));
            ch_rem_q[k] <= ch_trig[k] ? pw_q
                         : ((ch_rem_q[k] != '0) ? ch_rem_q[k] - PW_W'(1) : '0);
         end

         if (m_trig) frame_cnt_q <= frame_cnt_q + FCNT_W'(1);

         case (state_q)
            ST_IDLE: begin
               if (start_re && !i_stop) begin
                  if (cfg_bad) begin
                     cfg_err_q <= 1'b1;
                  end else begin
                     period_q    <= i_period;
                     pw_q        <= eff_pw;
                     mode_q      <= i_mode;
                     ch_en_q     <= i_ch_en;
                     for (int k = 0; k < NUM_CH; k++)
                        delay_q[k] <= i_ch_delay[k*CNT_W +: CNT_W];
                     cnt_q       <= '0;
                     frame_cnt_q <= '0;
                     cfg_err_q   <= |delay_bad;
                     state_q     <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               cnt_q <= cnt_last ? '0 : cnt_q + CNT_W'(1);
               if (i_stop || (mode_q && cnt_last)) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!master_q && (fs_q == '0)) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_master_fs = master_q;
   assign o_fs        = fs_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_frame_cnt = frame_cnt_q;
   assign o_cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_gen_framestart_multi.sv
// Self-checking bench for gen_framestart_multi: directed scenarios plus randomized runs, each
// compared cycle by cycle against an arithmetic model of the pulse timing.
module tb_gen_framestart_multi;
   localparam int NUM_CH = 3;
   localparam int CNT_W  = 32;
   localparam int PW_W   = 16;
   localparam int FCNT_W = 16;
   localparam int FCNT_S = 4;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    i_start = 1'b0;
   logic                    i_stop = 1'b0;
   logic                    i_mode = 1'b0;
   logic [CNT_W-1:0]        i_period = '0;
   logic [PW_W-1:0]         i_pulse_w = '0;
   logic [NUM_CH-1:0]       i_ch_en = '0;
   logic [NUM_CH*CNT_W-1:0] i_ch_delay = '0;
   logic                    o_master_fs, m4;
   logic [NUM_CH-1:0]       o_fs, fs4;
   logic                    o_busy, busy4;
   logic [FCNT_W-1:0]       o_frame_cnt;
   logic [FCNT_S-1:0]       fc4;
   logic                    o_cfg_err, err4;

   int n_checks = 0;
   int n_fail   = 0;
   bit exp_err  = 1'b0;

   always #5 clk = ~clk;

   gen_framestart_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PW_W(PW_W), .FCNT_W(FCNT_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
      .i_period(i_period), .i_pulse_w(i_pulse_w), .i_ch_en(i_ch_en), .i_ch_delay(i_ch_delay),
      .o_master_fs(o_master_fs), .o_fs(o_fs), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt),
      .o_cfg_err(o_cfg_err));

   gen_framestart_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PW_W(PW_W), .FCNT_W(FCNT_S)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
      .i_period(i_period), .i_pulse_w(i_pulse_w), .i_ch_en(i_ch_en), .i_ch_delay(i_ch_delay),
      .o_master_fs(m4), .o_fs(fs4), .o_busy(busy4), .o_frame_cnt(fc4), .o_cfg_err(err4));

   // Output level t edges after the start edge, for a source triggered whenever the run time
   // t' (t' < run_len) satisfies t' mod P == d; it is high during t' + 1 .. t' + pw.
   function automatic bit exp_pulse(input int t, input int d, input int p, input int pw,
                                    input int run_len);
      int tp;
      if (d >= p || t < 1 || (t - 1) < d) return 1'b0;
      tp = d + ((t - 1 - d) / p) * p;
      return (tp < run_len) && (tp >= t - pw);
   endfunction

   task automatic run_scenario(input string name, input int p, input int pw_in,
                               input logic [2:0] en, input int d0, input int d1, input int d2,
                               input bit mode, input int stop_at);
      int d[3];
      int pw, run_len, last_high, m_end, n, efc;
      bit em, eb;
      logic [2:0] efs;
      d = '{d0, d1, d2};
      pw = (pw_in == 0) ? 1 : pw_in;
      run_len = mode ? p : 32'h3fff_ffff;
      if (stop_at >= 0 && stop_at + 1 < run_len) run_len = stop_at + 1;
      last_high = 0;
      for (int t = 0; t <= run_len + pw + 2; t++) begin
         bit any;
         any = exp_pulse(t, 0, p, pw, run_len);
         for (int k = 0; k < 3; k++) any |= en[k] & exp_pulse(t, d[k], p, pw, run_len);
         if (any) last_high = t;
      end
      m_end = ((run_len > last_high + 1) ? run_len : last_high + 1) + 1;
      exp_err = 1'b0;
      for (int k = 0; k < 3; k++) if (d[k] >= p) exp_err = 1'b1;

      @(posedge clk); #1;
      i_period   = CNT_W'(p);
      i_pulse_w  = PW_W'(pw_in);
      i_ch_en    = en;
      i_ch_delay = {CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
      i_mode     = mode;
      i_start    = 1'b1;
      @(posedge clk); #1;
      i_start    = 1'b0;
      for (int t = 0; t <= m_end + 2; t++) begin
         if (t > 0) @(posedge clk);
         @(negedge clk);
         em = exp_pulse(t, 0, p, pw, run_len);
         for (int k = 0; k < 3; k++) efs[k] = en[k] & exp_pulse(t, d[k], p, pw, run_len);
         eb  = (t < m_end);
         n   = (t < run_len) ? t : run_len;
         efc = (n > 0) ? (n - 1) / p + 1 : 0;
         n_checks++;
         if (o_master_fs !== em) begin
            n_fail++;
            $display("FAIL %s master_fs t=%0d got=%b exp=%b", name, t, o_master_fs, em);
         end
         n_checks++;
         if (o_fs !== efs) begin
            n_fail++;
            $display("FAIL %s fs t=%0d got=%b exp=%b", name, t, o_fs, efs);
         end
         n_checks++;
         if (o_busy !== eb) begin
            n_fail++;
            $display("FAIL %s busy t=%0d got=%b exp=%b", name, t, o_busy, eb);
         end
         n_checks++;
         if (o_frame_cnt !== FCNT_W'(efc)) begin
            n_fail++;
            $display("FAIL %s frame_cnt t=%0d got=%0d exp=%0d", name, t, o_frame_cnt, FCNT_W'(efc));
         end
         n_checks++;
         if (o_cfg_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s cfg_err t=%0d got=%b exp=%b", name, t, o_cfg_err, exp_err);
         end
         n_checks++;
         if ({m4, fs4, busy4, fc4, err4} !== {em, efs, eb, FCNT_S'(efc), exp_err}) begin
            n_fail++;
            $display("FAIL %s small_cnt_inst t=%0d got=%b exp=%b", name, t,
                     {m4, fs4, busy4, fc4, err4}, {em, efs, eb, FCNT_S'(efc), exp_err});
         end
         if (t == 3) begin
            i_period   = $urandom;
            i_pulse_w  = PW_W'($urandom);
            i_ch_en    = NUM_CH'($urandom);
            i_ch_delay = {$urandom, $urandom, $urandom};
            i_mode     = ~i_mode;
         end
         if (t == stop_at) i_stop = 1'b1;
      end
      i_stop = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_checks++;
      if ({o_master_fs, o_fs, o_busy, o_frame_cnt, o_cfg_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got=%h exp=0", {o_master_fs, o_fs, o_busy, o_frame_cnt, o_cfg_err});
      end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({o_master_fs, o_fs, o_busy, o_frame_cnt, o_cfg_err} !== '0) begin
         n_fail++;
         $display("FAIL post_reset_idle got=%h exp=0", {o_master_fs, o_fs, o_busy, o_frame_cnt, o_cfg_err});
      end
   endtask

   task automatic bad_start(input string name, input int p, input int pw_in, input bit with_stop);
      @(posedge clk); #1;
      i_period  = CNT_W'(p);
      i_pulse_w = PW_W'(pw_in);
      i_ch_en   = 3'b111;
      i_ch_delay = '0;
      i_mode    = 1'b0;
      i_start   = 1'b1;
      i_stop    = with_stop;
      @(posedge clk); #1;
      i_start   = 1'b0;
      i_stop    = 1'b0;
      if (!with_stop) exp_err = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         n_checks++;
         if (o_busy !== 1'b0 || o_master_fs !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy/master t=%0d got=%b%b exp=00", name, t, o_busy, o_master_fs);
         end
         n_checks++;
         if (o_cfg_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s cfg_err t=%0d got=%b exp=%b", name, t, o_cfg_err, exp_err);
         end
      end
   endtask

   task automatic test_free_run();
      run_scenario("free_run", 1000, 10, 3'b111, 0, 250, 990, 1'b0, 2995);
   endtask

   task automatic test_single_shot();
      run_scenario("single_shot", 1000, 10, 3'b111, 0, 250, 990, 1'b1, -1);
   endtask

   task automatic test_stop_mid_pulse();
      run_scenario("stop_mid_pulse", 1000, 10, 3'b111, 0, 250, 990, 1'b0, 255);
   endtask

   task automatic test_cfg_err();
      bad_start("pw_eq_period", 1000, 1000, 1'b0);
      bad_start("period_one", 1, 0, 1'b0);
      bad_start("start_with_stop", 100, 5, 1'b1);
   endtask

   task automatic test_delay_err();
      run_scenario("delay_err", 1000, 10, 3'b111, 0, 250, 1200, 1'b1, -1);
   endtask

   task automatic test_pw_zero();
      run_scenario("pw_zero", 20, 0, 3'b111, 0, 5, 19, 1'b0, 45);
   endtask

   task automatic test_fcnt_wrap();
      run_scenario("fcnt_wrap", 3, 1, 3'b001, 0, 1, 2, 1'b0, 49);
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         int p, pw, stop_at;
         bit mode;
         p    = int'($urandom_range(2, 40));
         pw   = int'($urandom_range(0, p - 1));
         mode = 1'($urandom);
         if (!mode) stop_at = int'($urandom_range(0, 3 * p));
         else stop_at = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, p + 2));
         run_scenario($sformatf("rand%0d", i), p, pw, 3'($urandom),
                      int'($urandom_range(0, p + 3)), int'($urandom_range(0, p + 3)),
                      int'($urandom_range(0, p + 3)), mode, stop_at);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1;
      i_period   = 50;
      i_pulse_w  = 10;
      i_ch_en    = 3'b111;
      i_ch_delay = {CNT_W'(5), CNT_W'(60), CNT_W'(0)};
      i_mode     = 1'b0;
      i_start    = 1'b1;
      @(posedge clk); #1;
      i_start    = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if ({o_master_fs, o_fs[0], o_cfg_err} !== 3'b111) begin
         n_fail++;
         $display("FAIL pre_reset_pulse got=%b exp=111", {o_master_fs, o_fs[0], o_cfg_err});
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({o_master_fs, o_fs, o_busy, o_frame_cnt, o_cfg_err} !== '0) begin
         n_fail++;
         $display("FAIL async_reset got=%h exp=0", {o_master_fs, o_fs, o_busy, o_frame_cnt, o_cfg_err});
      end
      n_checks++;
      if ({m4, fs4, busy4, fc4, err4} !== '0) begin
         n_fail++;
         $display("FAIL async_reset_small got=%h exp=0", {m4, fs4, busy4, fc4, err4});
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_single_shot();
      test_stop_mid_pulse();
      test_cfg_err();
      test_delay_err();
      test_pw_zero();
      test_fcnt_wrap();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
